// File: rtl/wb_bus_mux.sv
// Classic Wishbone 1-master/N-slave interconnect with registered strobe/read data and unmapped-address error ack.
// Optional slave timeout: define WB_BUS_TIMEOUT_EN to error-ack a slave that stays silent for TIMEOUT BUSY cycles.
module wb_bus_mux #(
  parameter int N_SLAVES = 4,
  parameter int SEL_LSB  = 16,
  parameter int SEL_BITS = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     wb_cyc_i,
  input  logic                     wb_strobe_i,
  input  logic                     wb_we_i,
  input  logic [31:0]              wb_addr_i,
  input  logic [31:0]              wb_data_i,
  output logic [31:0]              wb_data_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic                     s_cyc_o,
  output logic                     s_we_o,
  output logic [31:0]              s_addr_o,
  output logic [31:0]              s_data_o,
  output logic [N_SLAVES-1:0]      s_strobe_o,
  input  logic [32*N_SLAVES-1:0]   s_data_i,
  input  logic [N_SLAVES-1:0]      s_ack_i
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP, ERR} state_t;

  // Out-of-range configurations elaborate to an empty, clearly named block.
  if (N_SLAVES < 1 || N_SLAVES > 16 || (1 << SEL_BITS) < N_SLAVES ||
      TIMEOUT < 1 || TIMEOUT > 65535) begin : g_unsupported_params
  end

  state_t              state_q, state_d;
  logic [SEL_BITS-1:0] idx_q, idx_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [31:0]         rdata_q, rdata_d;

  logic [SEL_BITS-1:0] req_idx;
  logic                req_mapped;
  logic                sel_ack;
  logic [31:0]         sel_data;
  logic [N_SLAVES-1:0] sel_onehot;

  assign req_idx    = wb_addr_i[SEL_LSB +: SEL_BITS];
  assign req_mapped = int'(req_idx) < N_SLAVES;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    sel_ack    = 1'b0;
    sel_data   = '0;
    sel_onehot = '0;
    for (int k = 0; k < N_SLAVES; k++) begin
      if (idx_q == SEL_BITS'(k)) begin
        sel_ack       = s_ack_i[k];
        sel_data      = s_data_i[32*k +: 32];
        sel_onehot[k] = 1'b1;
      end
    end
  end

`ifdef WB_BUS_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        timed_out;
  assign timed_out = (cnt_q == 16'(TIMEOUT));
`else
  logic        timed_out;
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
`ifdef WB_BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (wb_cyc_i && wb_strobe_i) begin
          idx_d   = req_idx;
          addr_d  = wb_addr_i;
          wdata_d = wb_data_i;
          we_d    = wb_we_i;
          state_d = req_mapped ? BUSY : ERR;
`ifdef WB_BUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        // An abort outranks a same-cycle ack; the selected ack outranks a timeout.
        if (!wb_cyc_i) begin
          state_d = IDLE;
        end else if (sel_ack) begin
          rdata_d = sel_data;
          state_d = RESP;
        end else if (timed_out) begin
          state_d = ERR;
        end
`ifdef WB_BUS_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
`ifdef WB_BUS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
`ifdef WB_BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  // All outputs are decoded from registered state, so they are glitch-free and clear with reset.
  assign s_cyc_o    = (state_q == BUSY);
  assign s_strobe_o = (state_q == BUSY) ? sel_onehot : '0;
  assign s_we_o     = we_q;
  assign s_addr_o   = addr_q;
  assign s_data_o   = wdata_q;
  assign wb_ack_o   = (state_q == RESP);
  assign wb_err_o   = (state_q == ERR);
  assign wb_data_o  = (state_q == RESP) ? rdata_q : '0;

endmodule
